// File: rtl/seg7_scan_driver_if.sv
// Bundles the digit-load inputs and display outputs of the 4-digit 7-segment scan driver.
interface seg7_scan_driver_if;
  logic       LOAD;
  logic [3:0] ONES;
  logic [3:0] TENS;
  logic [3:0] HUNDREDS;
  logic [3:0] THOUSANDS;
  logic [3:0] DP;
  logic       BLANK;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP_N;
  logic       FRAME;

  modport master (
    output LOAD, ONES, TENS, HUNDREDS, THOUSANDS, DP, BLANK,
    input  AN, SEG, DP_N, FRAME
  );

  modport slave (
    input  LOAD, ONES, TENS, HUNDREDS, THOUSANDS, DP, BLANK,
    output AN, SEG, DP_N, FRAME
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with tear-free frame commit,
// leading-zero blanking, ghost-guard blanking at each slot start and hex font fallback.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 16,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input logic              CLK,
  input logic              RST_N,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0]   div_cnt;
  logic [1:0]      idx;
  logic [3:0][3:0] disp;
  logic [3:0]      disp_dp;
  logic [3:0][3:0] pend;
  logic [3:0]      pend_dp;
  logic            pend_vld;

  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       dpn_q;

  logic       wrap;
  logic       frame;
  logic       digit_blank;
  logic       slot_dark;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dpn_d;

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'h0:    font = 7'h40;
      4'h1:    font = 7'h79;
      4'h2:    font = 7'h24;
      4'h3:    font = 7'h30;
      4'h4:    font = 7'h19;
      4'h5:    font = 7'h12;
      4'h6:    font = 7'h02;
      4'h7:    font = 7'h78;
      4'h8:    font = 7'h00;
      4'h9:    font = 7'h10;
      4'hA:    font = 7'h08;
      4'hB:    font = 7'h03;
      4'hC:    font = 7'h46;
      4'hD:    font = 7'h21;
      4'hE:    font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  assign wrap  = (div_cnt == CW'(REFRESH_DIV - 1));
  assign frame = wrap && (idx == 2'd3);

  always_comb begin
    digit_blank = 1'b0;
    if (LZ_BLANK) begin
      case (idx)
        2'd3:    digit_blank = (disp[3] == 4'd0);
        2'd2:    digit_blank = (disp[3] == 4'd0) && (disp[2] == 4'd0);
        2'd1:    digit_blank = (disp[3] == 4'd0) && (disp[2] == 4'd0) && (disp[1] == 4'd0);
        default: digit_blank = 1'b0;
      endcase
    end
    slot_dark = (div_cnt < CW'(GUARD)) || bus.BLANK || digit_blank;
    an_d  = '1;
    seg_d = '1;
    dpn_d = 1'b1;
    if (!slot_dark) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = font(disp[idx]);
      dpn_d = ~disp_dp[idx];
    end
  end

  // LOAD owns pend_vld on a commit edge so a coincident load stays pending.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      div_cnt  <= '0;
      idx      <= '0;
      disp     <= '0;
      disp_dp  <= '0;
      pend     <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
      an_q     <= '1;
      seg_q    <= '1;
      dpn_q    <= 1'b1;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      if (frame && pend_vld) begin
        disp    <= pend;
        disp_dp <= pend_dp;
      end
      if (bus.LOAD) begin
        pend     <= {bus.THOUSANDS, bus.HUNDREDS, bus.TENS, bus.ONES};
        pend_dp  <= bus.DP;
        pend_vld <= 1'b1;
      end else if (frame) begin
        pend_vld <= 1'b0;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dpn_q <= dpn_d;
    end
  end

  assign bus.AN    = an_q;
  assign bus.SEG   = seg_q;
  assign bus.DP_N  = dpn_q;
  assign bus.FRAME = frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed table-driven bench for seg7_scan_driver with REFRESH_DIV=8, GUARD=2, LZ_BLANK=1.
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;
  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .REFRESH_DIV(8),
    .GUARD      (2),
    .LZ_BLANK   (1'b1)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            blank;
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
    int unsigned     nload;
    logic [19:0]     l1;
    logic [19:0]     l2;
    logic            coinc;
    logic [19:0]     lc;
  } vec_t;

  vec_t vecs [10];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [19:0] p);
    bus.THOUSANDS = p[19:16];
    bus.HUNDREDS  = p[15:12];
    bus.TENS      = p[11:8];
    bus.ONES      = p[7:4];
    bus.DP        = p[3:0];
    bus.LOAD      = 1'b1;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (bus.FRAME !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("frame_wait", {31'd0, bus.FRAME}, 32'd1);
  endtask

  // Entered at the negedge where FRAME is high; the first posedge is the commit edge.
  // At negedge k the outputs reflect frame cycle k-2.
  task automatic check_frame(input vec_t v);
    bus.BLANK = v.blank;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.LOAD = 1'b0;
      if (v.nload >= 1 && k == 5)  drive(v.l1);
      if (v.nload >= 2 && k == 20) drive(v.l2);
      if (v.coinc && k == 32)      drive(v.lc);
      check("frame_pulse", {31'd0, bus.FRAME}, {31'd0, (k == 32)});
      for (int i = 0; i < 4; i++) begin
        if (k == i * 8 + 2 || k == i * 8 + 3)
          check($sformatf("an_guard[%0d]", i), {28'd0, bus.AN}, 32'hF);
        if (k == i * 8 + 6) begin
          check($sformatf("an[%0d]", i),   {28'd0, bus.AN},   {28'd0, v.an[i]});
          check($sformatf("seg[%0d]", i),  {25'd0, bus.SEG},  {25'd0, v.seg[i]});
          check($sformatf("dp_n[%0d]", i), {31'd0, bus.DP_N}, {31'd0, v.dpn[i]});
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    vecs[0] = '{1'b0, {4'hF,4'hF,4'hF,4'hE}, {7'h7F,7'h7F,7'h7F,7'h40}, 4'b1111,
                1, {4'h1,4'h2,4'h3,4'h4,4'h0}, 20'h0, 1'b0, 20'h0};
    vecs[1] = '{1'b0, {4'h7,4'hB,4'hD,4'hE}, {7'h79,7'h24,7'h30,7'h19}, 4'b1111,
                1, {4'h0,4'h0,4'h5,4'h0,4'h0}, 20'h0, 1'b0, 20'h0};
    vecs[2] = '{1'b0, {4'hF,4'hF,4'hD,4'hE}, {7'h7F,7'h7F,7'h12,7'h40}, 4'b1111,
                2, {4'h0,4'h0,4'h0,4'h7,4'h0}, {4'h0,4'h0,4'h0,4'h9,4'h0}, 1'b0, 20'h0};
    vecs[3] = '{1'b0, {4'hF,4'hF,4'hF,4'hE}, {7'h7F,7'h7F,7'h7F,7'h10}, 4'b1111,
                1, {4'hE,4'h0,4'h0,4'h0,4'b0001}, 20'h0, 1'b0, 20'h0};
    vecs[4] = '{1'b0, {4'h7,4'hB,4'hD,4'hE}, {7'h06,7'h40,7'h40,7'h40}, 4'b1110,
                0, 20'h0, 20'h0, 1'b0, 20'h0};
    vecs[5] = '{1'b1, {4'hF,4'hF,4'hF,4'hF}, {7'h7F,7'h7F,7'h7F,7'h7F}, 4'b1111,
                1, {4'h0,4'h0,4'h0,4'h7,4'b1110}, 20'h0, 1'b0, 20'h0};
    vecs[6] = '{1'b0, {4'hF,4'hF,4'hF,4'hE}, {7'h7F,7'h7F,7'h7F,7'h78}, 4'b1111,
                1, {4'h9,4'h8,4'h0,4'h6,4'b0100}, 20'h0, 1'b0, 20'h0};
    vecs[7] = '{1'b0, {4'h7,4'hB,4'hD,4'hE}, {7'h10,7'h00,7'h40,7'h02}, 4'b1011,
                1, {4'hF,4'hC,4'hB,4'hA,4'h0}, 20'h0, 1'b1, {4'h0,4'h0,4'h0,4'h0,4'b1111}};
    vecs[8] = '{1'b0, {4'h7,4'hB,4'hD,4'hE}, {7'h0E,7'h46,7'h03,7'h08}, 4'b1111,
                0, 20'h0, 20'h0, 1'b0, 20'h0};
    vecs[9] = '{1'b0, {4'hF,4'hF,4'hF,4'hE}, {7'h7F,7'h7F,7'h7F,7'h40}, 4'b1110,
                0, 20'h0, 20'h0, 1'b0, 20'h0};
    z = vecs[0];
    z.nload = 0;

    rst_n         = 1'b0;
    bus.LOAD      = 1'b0;
    bus.BLANK     = 1'b0;
    bus.ONES      = '0;
    bus.TENS      = '0;
    bus.HUNDREDS  = '0;
    bus.THOUSANDS = '0;
    bus.DP        = '0;
    repeat (3) @(negedge clk);
    check("rst_an",    {28'd0, bus.AN},    32'hF);
    check("rst_seg",   {25'd0, bus.SEG},   32'h7F);
    check("rst_dp_n",  {31'd0, bus.DP_N},  32'd1);
    check("rst_frame", {31'd0, bus.FRAME}, 32'd0);
    rst_n = 1'b1;

    wait_frame();
    for (int v = 0; v < 10; v++) check_frame(vecs[v]);

    // Reset during the idx=2 slot with a load still pending.
    bus.LOAD = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk);
      @(negedge clk);
      bus.LOAD = 1'b0;
      if (n == 10) drive({4'h1,4'h2,4'h3,4'h4,4'h0});
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_an",    {28'd0, bus.AN},    32'hF);
    check("midrst_seg",   {25'd0, bus.SEG},   32'h7F);
    check("midrst_dp_n",  {31'd0, bus.DP_N},  32'd1);
    check("midrst_frame", {31'd0, bus.FRAME}, 32'd0);
    rst_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 2) check("postrst_guard", {28'd0, bus.AN}, 32'hF);
      if (n == 4) begin
        check("postrst_an0",  {28'd0, bus.AN},  32'hE);
        check("postrst_seg0", {25'd0, bus.SEG}, 32'h40);
      end
    end
    wait_frame();
    check_frame(z);

    bus.LOAD = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
